// File: rtl/soin_gshare_predictor_if.sv
// soin_gshare_predictor_if
//   Bundles the fetch lookup, prediction result and execute-resolution
//   signals of the gshare predictor.
//   Modports:
//     master - fetch/execute side: drives lookups and resolutions, reads predictions.
//     slave  - predictor side: reads lookups and resolutions, drives predictions.
//   Signal groups:
//     fetch_*  lookup request (cycle N) and pre-decoded class/target (cycle N+1)
//     bp_*     prediction outputs (cycle N+1) and init-sweep status
//     ex_*     resolved-branch feedback with the meta returned from bp_meta
interface soin_gshare_predictor_if #(
  parameter int GHR_W = 8,
  parameter int IDX_W = 12,
  parameter int RAS_L = 4
);
  localparam int META_W = RAS_L + 2 + GHR_W + IDX_W;

  logic              fetch_valid;
  logic [31:0]       fetch_PC;
  logic              fetch_is_cond;
  logic              fetch_is_call;
  logic              fetch_is_ret;
  logic              fetch_is_jmp;
  logic [31:0]       fetch_br_target;

  logic              bp_valid;
  logic              bp_p_dir;
  logic [31:0]       bp_p_target;
  logic [META_W-1:0] bp_meta;
  logic              bp_init_busy;

  logic              ex_update;
  logic              ex_dir;
  logic              ex_miss;
  logic              ex_is_cond;
  logic              ex_recover_ras;
  logic [META_W-1:0] ex_meta;

  modport master (
    output fetch_valid, fetch_PC, fetch_is_cond, fetch_is_call, fetch_is_ret,
           fetch_is_jmp, fetch_br_target,
    output ex_update, ex_dir, ex_miss, ex_is_cond, ex_recover_ras, ex_meta,
    input  bp_valid, bp_p_dir, bp_p_target, bp_meta, bp_init_busy
  );

  modport slave (
    input  fetch_valid, fetch_PC, fetch_is_cond, fetch_is_call, fetch_is_ret,
           fetch_is_jmp, fetch_br_target,
    input  ex_update, ex_dir, ex_miss, ex_is_cond, ex_recover_ras, ex_meta,
    output bp_valid, bp_p_dir, bp_p_target, bp_meta, bp_init_busy
  );
endinterface

// File: rtl/soin_gshare_predictor.sv
// soin_gshare_predictor
//   Gshare direction predictor: 2^IDX_W two-bit saturating counters indexed by
//   PC[IDX_W+1:2] XOR global history, speculative history with repair from
//   execute, and a circular 2^RAS_L-entry return-address stack.
//   After reset the table is swept to weakly-not-taken (2'b01), one entry per
//   cycle; lookups, updates, history and RAS activity are held off until done.
//   Ports:
//     clk    clock
//     reset  synchronous active-high reset (restarts the init sweep)
//     bp     soin_gshare_predictor_if.slave (fetch lookup, prediction, execute feedback)
//   bp_meta layout: {ras_tos, ctr[1:0], ghr, idx}, idx in the LSBs.
//   Build option:
//     SOIN_BP_WR_BYPASS_EN  when defined, a same-cycle counter write to the
//                           looked-up index is forwarded into the lookup result;
//                           otherwise the lookup returns the stale counter.
module soin_gshare_predictor #(
  parameter int GHR_W = 8,
  parameter int IDX_W = 12,
  parameter int RAS_L = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  soin_gshare_predictor_if.slave bp
);
  localparam int META_W  = RAS_L + 2 + GHR_W + IDX_W;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int RAS_N   = 1 << RAS_L;
  localparam int CTR_LSB = IDX_W + GHR_W;
  localparam int TOS_LSB = IDX_W + GHR_W + 2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Control state
  logic [0:0]       state_q,    state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [GHR_W-1:0] ghr_q,      ghr_d;
  logic [RAS_L-1:0] tos_q,      tos_d;
  logic             lk_vld_q,   lk_vld_d;

  // Lookup capture (cycle N -> N+1)
  logic [31:0]      lk_pc_q,    lk_pc_d;
  logic [IDX_W-1:0] lk_idx_q,   lk_idx_d;
  logic [GHR_W-1:0] lk_ghr_q,   lk_ghr_d;
  logic             byp_hit_q,  byp_hit_d;
  logic [1:0]       byp_val_q,  byp_val_d;
  logic [1:0]       tab_rd_q;

  // Storage
  logic [1:0]       ctr_tab [ENTRIES];
  logic [31:0]      ras_q   [RAS_N];

  // Combinational nets
  logic             run;
  logic [1:0]       lk_ctr;
  logic             p_dir;
  logic [31:0]      p_target;
  logic [IDX_W-1:0] ex_idx;
  logic [GHR_W-1:0] ex_ghr;
  logic [1:0]       ex_ctr;
  logic [RAS_L-1:0] ex_tos;
  logic [1:0]       upd_val;
  logic             tab_we;
  logic [IDX_W-1:0] tab_widx;
  logic [1:0]       tab_wval;
  logic             push, pop, recover, ras_we;
  logic [RAS_L-1:0] ras_widx;

  always_comb begin
    run     = (state_q == ST_RUN);

    ex_idx  = bp.ex_meta[IDX_W-1:0];
    ex_ghr  = bp.ex_meta[IDX_W +: GHR_W];
    ex_ctr  = bp.ex_meta[CTR_LSB +: 2];
    ex_tos  = bp.ex_meta[TOS_LSB +: RAS_L];
    upd_val = bp.ex_dir ? sat_inc(ex_ctr) : sat_dec(ex_ctr);

    // Lookup, cycle N. Only accepted once the sweep is done.
    lk_idx_d = bp.fetch_PC[IDX_W+1:2] ^ IDX_W'(ghr_q);
    lk_vld_d = run & bp.fetch_valid;
    lk_pc_d  = bp.fetch_valid ? bp.fetch_PC : lk_pc_q;
    lk_ghr_d = ghr_q;
`ifdef SOIN_BP_WR_BYPASS_EN
    byp_hit_d = run & bp.ex_update & (ex_idx == lk_idx_d);
`else
    byp_hit_d = 1'b0;
`endif
    byp_val_d = upd_val;

    // Prediction, cycle N+1
    lk_ctr = byp_hit_q ? byp_val_q : tab_rd_q;
    p_dir  = lk_vld_q & (bp.fetch_is_cond ? lk_ctr[1]
                        : (bp.fetch_is_call | bp.fetch_is_ret | bp.fetch_is_jmp));
    if (!p_dir)               p_target = lk_pc_q + 32'd4;
    else if (bp.fetch_is_ret) p_target = ras_q[tos_q];
    else                      p_target = bp.fetch_br_target;

    // Single table write port shared by the init sweep and execute updates
    if (!run) begin
      tab_we   = 1'b1;
      tab_widx = init_idx_q;
      tab_wval = 2'b01;
    end else begin
      tab_we   = bp.ex_update;
      tab_widx = ex_idx;
      tab_wval = upd_val;
    end

    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (!run) begin
      init_idx_d = init_idx_q + IDX_W'(1);
      if (&init_idx_q) state_d = ST_RUN;
    end

    // Repair outranks the speculative shift of this cycle's prediction
    ghr_d = ghr_q;
    if (run && bp.ex_miss)
      ghr_d = bp.ex_is_cond ? {ex_ghr[GHR_W-2:0], bp.ex_dir} : ex_ghr;
    else if (lk_vld_q && bp.fetch_is_cond)
      ghr_d = {ghr_q[GHR_W-2:0], p_dir};

    // RAS: call beats ret; recovery beats both and also cancels the push write
    push     = lk_vld_q & bp.fetch_is_call;
    pop      = lk_vld_q & bp.fetch_is_ret & ~bp.fetch_is_call;
    recover  = run & bp.ex_recover_ras;
    ras_widx = tos_q + RAS_L'(1);
    ras_we   = push & ~recover;
    tos_d    = tos_q;
    if (recover)   tos_d = ex_tos;
    else if (push) tos_d = ras_widx;
    else if (pop)  tos_d = tos_q - RAS_L'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
      tos_q      <= '0;
      lk_vld_q   <= 1'b0;
      lk_pc_q    <= '0;
      byp_hit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
      tos_q      <= tos_d;
      lk_vld_q   <= lk_vld_d;
      lk_pc_q    <= lk_pc_d;
      byp_hit_q  <= byp_hit_d;
    end
  end

  // Unreset lookup capture; only observed alongside lk_vld_q.
  always_ff @(posedge clk) begin
    lk_idx_q  <= lk_idx_d;
    lk_ghr_q  <= lk_ghr_d;
    byp_val_q <= byp_val_d;
  end

  // Registered table read is read-before-write against the same-edge update.
  always_ff @(posedge clk) begin
    if (tab_we) ctr_tab[tab_widx] <= tab_wval;
    tab_rd_q <= ctr_tab[lk_idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAS_N; i++) ras_q[i] <= '0;
    end else if (ras_we) begin
      ras_q[ras_widx] <= lk_pc_q + 32'd4;
    end
  end

  assign bp.bp_valid     = lk_vld_q;
  assign bp.bp_p_dir     = p_dir;
  assign bp.bp_p_target  = p_target;
  // Meta is only meaningful with bp_valid; zero otherwise (covers unreset read data).
  assign bp.bp_meta      = lk_vld_q ? {tos_q, lk_ctr, lk_ghr_q, lk_idx_q} : '0;
  assign bp.bp_init_busy = ~run;

endmodule

// File: tb/tb_soin_gshare_predictor.sv
// tb_soin_gshare_predictor
//   Drives soin_gshare_predictor through reset and the init sweep, directed
//   training / history-repair / RAS / recovery / bypass scenarios, then
//   randomized traffic, comparing every prediction against a behavioural model.
module tb_soin_gshare_predictor;
  localparam int GHR_W = 8;
  localparam int IDX_W = 12;
  localparam int RAS_L = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  soin_gshare_predictor_if #(.GHR_W(GHR_W), .IDX_W(IDX_W), .RAS_L(RAS_L)) bif();

  soin_gshare_predictor #(.GHR_W(GHR_W), .IDX_W(IDX_W), .RAS_L(RAS_L)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model
  int          m_ctr [4096];
  int          m_ghr, m_tos;
  logic [31:0] m_ras [16];
  bit          m_pv;
  int          m_pidx, m_pctr, m_pghr;
  logic [31:0] m_ppc;

  // Last sampled outputs for directed checks
  logic        l_dir;
  logic [31:0] l_tgt;
  logic [25:0] l_meta;

  function automatic logic [25:0] mk_meta(input int tos, input int ctr, input int ghr, input int idx);
    logic [31:0] v;
    v = (32'(tos & 15) << 22) | (32'(ctr & 3) << 20) | (32'(ghr & 255) << 12) | 32'(idx & 4095);
    return v[25:0];
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ m_ghr) & 4095) << 2);
  endfunction

  task automatic clear_inputs();
    bif.fetch_valid = 0; bif.fetch_PC = 0;
    bif.fetch_is_cond = 0; bif.fetch_is_call = 0; bif.fetch_is_ret = 0; bif.fetch_is_jmp = 0;
    bif.fetch_br_target = 0;
    bif.ex_update = 0; bif.ex_dir = 0; bif.ex_miss = 0; bif.ex_is_cond = 0;
    bif.ex_recover_ras = 0; bif.ex_meta = 0;
  endtask

  // One clock cycle: compare at negedge, advance model, step past posedge.
  task automatic tick();
    int e_dir, nidx, nctr, og, ui, ug, uc, ut, nc;
    logic [31:0] e_tgt, pc;
    logic [25:0] em;
    bit nv;
    @(negedge clk);
    l_dir = bif.bp_p_dir; l_tgt = bif.bp_p_target; l_meta = bif.bp_meta;
    check("valid", 32'(bif.bp_valid), 32'(m_pv));
    e_dir = 0;
    if (m_pv) begin
      if (bif.fetch_is_cond) e_dir = (m_pctr >= 2) ? 1 : 0;
      else e_dir = (bif.fetch_is_call || bif.fetch_is_ret || bif.fetch_is_jmp) ? 1 : 0;
      if (e_dir == 0)        e_tgt = m_ppc + 32'd4;
      else if (bif.fetch_is_ret) e_tgt = m_ras[m_tos];
      else                   e_tgt = bif.fetch_br_target;
      check("dir", 32'(bif.bp_p_dir), 32'(e_dir));
      check("target", bif.bp_p_target, e_tgt);
      check("meta", 32'(bif.bp_meta), 32'(mk_meta(m_tos, m_pctr, m_pghr, m_pidx)));
    end
    og = m_ghr;
    nv = bif.fetch_valid;
    pc = bif.fetch_PC;
    nidx = 0; nctr = 0;
    if (nv) begin
      nidx = int'((pc >> 2) & 32'hFFF) ^ m_ghr;
      nctr = m_ctr[nidx];
    end
    em = bif.ex_meta;
    ui = int'(em[11:0]); ug = int'(em[19:12]); uc = int'(em[21:20]); ut = int'(em[25:22]);
    if (bif.ex_update) begin
      nc = bif.ex_dir ? ((uc == 3) ? 3 : uc + 1) : ((uc == 0) ? 0 : uc - 1);
`ifdef SOIN_BP_WR_BYPASS_EN
      if (nv && nidx == ui) nctr = nc;
`endif
      m_ctr[ui] = nc;
    end
    if (bif.ex_miss) m_ghr = bif.ex_is_cond ? (((ug << 1) | int'(bif.ex_dir)) & 255) : ug;
    else if (m_pv && bif.fetch_is_cond) m_ghr = ((m_ghr << 1) | e_dir) & 255;
    if (bif.ex_recover_ras) m_tos = ut;
    else if (m_pv && bif.fetch_is_call) begin
      m_tos = (m_tos + 1) % 16;
      m_ras[m_tos] = m_ppc + 32'd4;
    end else if (m_pv && bif.fetch_is_ret) m_tos = (m_tos + 15) % 16;
    m_pv = nv;
    if (nv) begin m_pidx = nidx; m_pctr = nctr; m_pghr = og; m_ppc = pc; end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Lookup in one cycle, present class {cond,call,ret,jmp} and target in the next.
  task automatic lookup(input logic [31:0] pc, input logic [3:0] cls, input logic [31:0] tgt);
    bif.fetch_valid = 1; bif.fetch_PC = pc;
    tick();
    {bif.fetch_is_cond, bif.fetch_is_call, bif.fetch_is_ret, bif.fetch_is_jmp} = cls;
    bif.fetch_br_target = tgt;
    tick();
  endtask

  localparam logic [3:0] C_NONE = 4'b0000, C_COND = 4'b1000, C_CALL = 4'b0100, C_RET = 4'b0010;

  int n;
  bit saw_valid;
  int r;
  int exp_byp;

  initial begin
    reset = 1;
    clear_inputs();
    for (int i = 0; i < 4096; i++) m_ctr[i] = 1;
    for (int i = 0; i < 16; i++) m_ras[i] = 0;
    m_ghr = 0; m_tos = 0; m_pv = 0; m_pidx = 0; m_pctr = 0; m_pghr = 0; m_ppc = 0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 32'(bif.bp_valid), 0);
    check("rst_busy", 32'(bif.bp_init_busy), 1);
    check("rst_target", bif.bp_p_target, 32'h4);
    check("rst_dir", 32'(bif.bp_p_dir), 0);
    check("rst_meta", 32'(bif.bp_meta), 0);

    // Activity during the sweep must be ignored.
    @(posedge clk); #1;
    reset = 0;
    bif.fetch_valid = 1; bif.fetch_PC = 32'h40; bif.fetch_is_cond = 1; bif.fetch_is_call = 1;
    bif.ex_update = 1; bif.ex_dir = 1; bif.ex_meta = mk_meta(5, 3, 8'h55, 0);
    bif.ex_miss = 1; bif.ex_is_cond = 0; bif.ex_recover_ras = 1;
    repeat (50) @(posedge clk);
    #1;
    reset = 1;                         // mid-sweep reset restarts at index 0
    @(posedge clk); #1;
    reset = 0;
    n = 0; saw_valid = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (!bif.bp_init_busy) break;
      n++;
      if (bif.bp_valid) saw_valid = 1;
      if (n == 4000) clear_inputs();
    end
    check("sweep_len", 32'(n), 32'd4096);
    check("sweep_no_valid", 32'(saw_valid), 0);
    @(posedge clk); #1;

    // First cond lookup after the sweep (idx 0 was targeted during the sweep)
    lookup(32'h0, C_COND, 32'h1000);
    check("first_dir", 32'(l_dir), 0);
    check("first_ctr", 32'(l_meta[21:20]), 32'h1);
    check("init_ghr", 32'(l_meta[19:12]), 0);
    check("init_tos", 32'(l_meta[25:22]), 0);

    // Training at idx 0x010
    for (int k = 1; k <= 2; k++) begin
      bif.ex_update = 1; bif.ex_dir = 1; bif.ex_meta = mk_meta(0, k, 0, 12'h010);
      tick();
    end
    lookup(pc_for(12'h010), C_COND, 32'h2000);
    check("trained_dir", 32'(l_dir), 1);
    check("trained_tgt", l_tgt, 32'h2000);
    check("trained_ctr", 32'(l_meta[21:20]), 32'h3);
    repeat (5) begin
      bif.ex_update = 1; bif.ex_dir = 1; bif.ex_meta = mk_meta(0, 3, 0, 12'h010);
      tick();
    end
    lookup(pc_for(12'h010), C_COND, 32'h2400);
    check("sat_ctr", 32'(l_meta[21:20]), 32'h3);

    // GHR: clear, three taken conds, then repair with a concurrent fetch shift
    bif.ex_miss = 1; bif.ex_is_cond = 0; bif.ex_meta = mk_meta(0, 0, 0, 0);
    tick();
    repeat (3) lookup(pc_for(12'h010), C_COND, 32'h3000);
    lookup(pc_for(12'h020), C_NONE, 32'h0);
    check("ghr_3taken", 32'(l_meta[19:12]), 32'h07);
    bif.fetch_valid = 1; bif.fetch_PC = pc_for(12'h010);
    tick();
    bif.fetch_is_cond = 1; bif.fetch_br_target = 32'h3100;
    bif.ex_miss = 1; bif.ex_is_cond = 1; bif.ex_dir = 0; bif.ex_meta = mk_meta(0, 0, 8'h01, 0);
    tick();
    check("repair_fetch_dir", 32'(l_dir), 1);
    lookup(32'h1234, C_NONE, 32'h0);
    check("ghr_repaired", 32'(l_meta[19:12]), 32'h02);

    // RAS
    lookup(32'h100, C_CALL, 32'h5000);
    check("call_tgt", l_tgt, 32'h5000);
    lookup(32'h5000, C_RET, 32'h0);
    check("ret_tgt", l_tgt, 32'h104);
    for (int k = 0; k < 17; k++)
      lookup(32'h2000 + 32'(16 * k), C_CALL, 32'h2000 + 32'(16 * (k + 1)));
    for (int k = 0; k < 17; k++) begin
      lookup(32'h9000, C_RET, 32'h0);
      if (k == 0)  check("ret_first_wrap", l_tgt, 32'h2104);
      if (k == 16) check("ret_17_overwrote", l_tgt, 32'h2104);
    end

    // RAS recovery beats a concurrent call
    bif.fetch_valid = 1; bif.fetch_PC = 32'h700;
    tick();
    bif.fetch_is_call = 1; bif.fetch_br_target = 32'h800;
    bif.ex_recover_ras = 1; bif.ex_meta = mk_meta(3, 0, 0, 0);
    tick();
    lookup(32'h800, C_NONE, 32'h0);
    check("recover_tos", 32'(l_meta[25:22]), 32'h3);

    // Same-cycle write/read at idx 0x123 (still 01)
    bif.fetch_valid = 1; bif.fetch_PC = pc_for(12'h123);
    bif.ex_update = 1; bif.ex_dir = 1; bif.ex_meta = mk_meta(0, 1, 0, 12'h123);
    tick();
    tick();
`ifdef SOIN_BP_WR_BYPASS_EN
    exp_byp = 2;
`else
    exp_byp = 1;
`endif
    check("bypass_idx", 32'(l_meta[11:0]), 32'h123);
    check("bypass_ctr", 32'(l_meta[21:20]), 32'(exp_byp));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bif.fetch_valid = ($urandom_range(0, 3) != 0);
      bif.fetch_PC = $urandom;
      r = $urandom_range(0, 7);
      bif.fetch_is_cond = (r == 1 || r == 2);
      bif.fetch_is_call = (r == 3 || r == 6);
      bif.fetch_is_ret  = (r == 4 || r == 6);
      bif.fetch_is_jmp  = (r == 5);
      bif.fetch_br_target = $urandom;
      bif.ex_update = ($urandom_range(0, 9) < 3);
      bif.ex_dir = 1'($urandom_range(0, 1));
      bif.ex_miss = ($urandom_range(0, 9) == 0);
      bif.ex_is_cond = 1'($urandom_range(0, 1));
      bif.ex_recover_ras = ($urandom_range(0, 19) == 0);
      bif.ex_meta = 26'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
